// File: rtl/logic_gate_unit.sv
// -----------------------------------------------------------------------------
// logic_gate_unit
//
// Registered multi-function logic gate with valid/ready handshakes on both
// sides and a single output register stage. One of eight gate functions
// (AND, OR, NAND, NOR, XOR, XNOR, NOT, BUF) is applied in one of three modes:
//   BITWISE : out_y = a op b across WIDTH bits (mode 0, and reserved mode 3)
//   REDUCE  : out_y = zero-extended 1-bit reduction of a (mode 1)
//   ACCUM   : op folded across all beats of a packet, emitted on in_last (mode 2)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready at a clk edge
//   in_a       operand A
//   in_b       operand B (BITWISE only)
//   in_op      0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 BUF(a)
//   in_mode    0 BITWISE, 1 REDUCE, 2 ACCUM, 3 treated as BITWISE
//   in_last    last beat of an ACCUM packet
//   out_valid  result valid
//   out_ready  consumer accepts result when out_valid & out_ready
//   out_y      result
//   out_beats  number of beats behind out_y, saturating at 2^CNT_W-1
// -----------------------------------------------------------------------------
module logic_gate_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic [1:0]       in_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [CNT_W-1:0] out_beats
);

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_BUF  = 3'd7;

   localparam logic [1:0] MODE_REDUCE = 2'd1;
   localparam logic [1:0] MODE_ACCUM  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Gate functions
   // ---------------------------------------------------------------------------
   function automatic logic [WIDTH-1:0] bitwise_op(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         OP_NOT:  r = ~a;
         default: r = a;
      endcase
      return r;
   endfunction

   function automatic logic reduce_op(input logic [2:0] op,
                                      input logic [WIDTH-1:0] a);
      logic r;
      case (op)
         OP_AND:  r = &a;
         OP_OR:   r = |a;
         OP_NAND: r = ~&a;
         OP_NOR:  r = ~|a;
         OP_XOR:  r = ^a;
         OP_XNOR: r = ~^a;
         OP_NOT:  r = ~a[0];
         default: r = a[0];
      endcase
      return r;
   endfunction

   // Accumulation uses the non-inverted base operator; the inversion of
   // NAND/NOR/XNOR/NOT is applied once, at emit time, by finalize_op.
   function automatic logic [WIDTH-1:0] accum_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] a);
      logic [WIDTH-1:0] r;
      case (op)
         OP_AND, OP_NAND: r = acc & a;
         OP_OR,  OP_NOR:  r = acc | a;
         OP_XOR, OP_XNOR: r = acc ^ a;
         default:         r = a;       // NOT/BUF: last beat wins
      endcase
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] finalize_op(input logic [2:0] op,
                                                    input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (op)
         OP_NAND, OP_NOR, OP_XNOR, OP_NOT: r = ~v;
         default:                          r = v;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_ONE;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_y_q, out_y_d;
   logic [CNT_W-1:0] out_beats_q, out_beats_d;

   logic             accept;
   logic [WIDTH-1:0] acc_next;
   logic [CNT_W-1:0] cnt_next;

   // in_ready depends combinationally on out_ready so the output register can
   // be refilled in the same cycle it is drained.
   assign in_ready = ~rst & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_beats_d = out_beats_q;
      acc_next    = acc_q;
      cnt_next    = cnt_q;

      // Drained result: clear valid unless a new result is written below.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (state_q == ACC) begin
            // Mid-packet: op, mode and b come from the packet's first beat.
            acc_next = accum_op(op_q, acc_q, in_a);
            cnt_next = cnt_sat_inc(cnt_q);
            if (in_last) begin
               out_valid_d = 1'b1;
               out_y_d     = finalize_op(op_q, acc_next);
               out_beats_d = cnt_next;
               acc_d       = '0;
               cnt_d       = '0;
               state_d     = IDLE;
            end else begin
               acc_d = acc_next;
               cnt_d = cnt_next;
            end
         end else if (in_mode == MODE_ACCUM) begin
            op_d     = in_op;
            acc_next = in_a;
            cnt_next = CNT_ONE;
            if (in_last) begin
               out_valid_d = 1'b1;
               out_y_d     = finalize_op(in_op, acc_next);
               out_beats_d = cnt_next;
               acc_d       = '0;
               cnt_d       = '0;
            end else begin
               acc_d   = acc_next;
               cnt_d   = cnt_next;
               state_d = ACC;
            end
         end else if (in_mode == MODE_REDUCE) begin
            out_valid_d = 1'b1;
            out_y_d     = WIDTH'(reduce_op(in_op, in_a));
            out_beats_d = CNT_ONE;
         end else begin
            out_valid_d = 1'b1;
            out_y_d     = bitwise_op(in_op, in_a, in_b);
            out_beats_d = CNT_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_AND;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_beats_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_beats_q <= out_beats_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_beats = out_beats_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_gate_unit
//
// Directed bench for logic_gate_unit (WIDTH=8, CNT_W=2 so that counter
// saturation is reachable with short packets). Single-beat BITWISE/REDUCE
// cases run from a vector table; reset, ACCUM packets, backpressure and
// saturation run as hand-written sequences. Inputs change 1 ns after the
// rising edge, outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_logic_gate_unit;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic [1:0]       in_mode;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic [CNT_W-1:0] out_beats;

   int n_total;
   int n_pass;

   logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_mode   (in_mode),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_beats (out_beats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [1:0] mode;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic [1:0] beats;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Present one beat, let it be clocked in, then return 1 ns after the edge.
   task automatic beat(input logic [2:0] op, input logic [1:0] mode,
                       input logic [7:0] a, input logic [7:0] b, input logic last);
      in_valid = 1'b1;
      in_op    = op;
      in_mode  = mode;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_y",     32'(out_y),     32'd0);
      chk("rst_out_beats", 32'(out_beats), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      #1 rst = 1'b0;
      #1;
      chk("rst_release_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;

      // BITWISE sweep a=C5, b=3A; REDUCE cases; reserved mode 3 as BITWISE.
      vecs[0]  = '{"bw_and",  3'd0, 2'd0, 8'hC5, 8'h3A, 8'h00, 2'd1};
      vecs[1]  = '{"bw_or",   3'd1, 2'd0, 8'hC5, 8'h3A, 8'hFF, 2'd1};
      vecs[2]  = '{"bw_nand", 3'd2, 2'd0, 8'hC5, 8'h3A, 8'hFF, 2'd1};
      vecs[3]  = '{"bw_nor",  3'd3, 2'd0, 8'hC5, 8'h3A, 8'h00, 2'd1};
      vecs[4]  = '{"bw_xor",  3'd4, 2'd0, 8'hC5, 8'h3A, 8'hFF, 2'd1};
      vecs[5]  = '{"bw_xnor", 3'd5, 2'd0, 8'hC5, 8'h3A, 8'h00, 2'd1};
      vecs[6]  = '{"bw_not",  3'd6, 2'd0, 8'hC5, 8'h3A, 8'h3A, 2'd1};
      vecs[7]  = '{"bw_buf",  3'd7, 2'd0, 8'hC5, 8'h3A, 8'hC5, 2'd1};
      vecs[8]  = '{"rd_and",  3'd0, 2'd1, 8'hFF, 8'h00, 8'h01, 2'd1};
      vecs[9]  = '{"rd_nor",  3'd3, 2'd1, 8'h00, 8'hFF, 8'h01, 2'd1};
      vecs[10] = '{"rd_xor",  3'd4, 2'd1, 8'h07, 8'h00, 8'h01, 2'd1};
      vecs[11] = '{"rd_xnor", 3'd5, 2'd1, 8'h07, 8'h00, 8'h00, 2'd1};
      vecs[12] = '{"rd_not",  3'd6, 2'd1, 8'h06, 8'h00, 8'h01, 2'd1};
      vecs[13] = '{"rd_buf",  3'd7, 2'd1, 8'h06, 8'h00, 8'h00, 2'd1};
      vecs[14] = '{"m3_xor",  3'd4, 2'd3, 8'hF0, 8'hFF, 8'h0F, 2'd1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = '0;
      in_mode   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset values
      #2;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_y",     32'(out_y),     32'd0);
      chk("reset_out_beats", 32'(out_beats), 32'd0);
      chk("reset_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Table: back-to-back beats, each result one cycle after its beat.
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         in_op    = vecs[i].op;
         in_mode  = vecs[i].mode;
         in_a     = vecs[i].a;
         in_b     = vecs[i].b;
         in_last  = 1'b0;
         chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
         chk({vecs[i].name, "_y"},     32'(out_y),     32'(vecs[i].y));
         chk({vecs[i].name, "_beats"}, 32'(out_beats), 32'(vecs[i].beats));
      end
      idle_cycle();
      chk("table_drain_valid", 32'(out_valid), 32'd0);

      // Async reset mid-cycle while a result is pending.
      beat(3'd0, 2'd0, 8'hFF, 8'hFF, 1'b0);
      chk("prerst_valid", 32'(out_valid), 32'd1);
      chk("prerst_y",     32'(out_y),     32'hFF);
      pulse_reset();
      idle_cycle();

      // ACCUM NAND over F0, 3C, FF; op change on beat 2 ignored.
      beat(3'd2, 2'd2, 8'hF0, 8'h00, 1'b0);
      chk("nand_b1_valid", 32'(out_valid), 32'd0);
      beat(3'd1, 2'd0, 8'h3C, 8'h55, 1'b0);
      chk("nand_b2_valid", 32'(out_valid), 32'd0);
      beat(3'd1, 2'd1, 8'hFF, 8'h00, 1'b1);
      chk("nand_valid", 32'(out_valid), 32'd1);
      chk("nand_y",     32'(out_y),     32'hCF);
      chk("nand_beats", 32'(out_beats), 32'd3);
      idle_cycle();
      chk("nand_single_output", 32'(out_valid), 32'd0);

      // Backpressure: first result 0F, consumer stalls 3 cycles.
      beat(3'd0, 2'd0, 8'h0F, 8'hFF, 1'b0);
      chk("bp_first_y", 32'(out_y), 32'h0F);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = 3'd1;
      in_mode   = 2'd0;
      in_a      = 8'hF0;
      in_b      = 8'h0F;
      in_last   = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("bp_stall_in_ready", 32'(in_ready),  32'd0);
         @(posedge clk);
         #1;
         chk("bp_stall_valid",    32'(out_valid), 32'd1);
         chk("bp_stall_y",        32'(out_y),     32'h0F);
         chk("bp_stall_beats",    32'(out_beats), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_next_valid", 32'(out_valid), 32'd1);
      chk("bp_next_y",     32'(out_y),     32'hFF);
      idle_cycle();
      chk("bp_no_dup", 32'(out_valid), 32'd0);

      // Saturation: XOR over 5 beats of 01 with a 2-bit counter.
      for (int k = 0; k < 4; k++) begin
         beat(3'd4, 2'd2, 8'h01, 8'h00, 1'b0);
         chk("sat_nolast_valid", 32'(out_valid), 32'd0);
      end
      beat(3'd4, 2'd2, 8'h01, 8'h00, 1'b1);
      chk("sat_valid", 32'(out_valid), 32'd1);
      chk("sat_y",     32'(out_y),     32'h01);
      chk("sat_beats", 32'(out_beats), 32'd3);
      idle_cycle();

      // Reset after beat 2 discards the packet; a 1-beat packet follows.
      beat(3'd4, 2'd2, 8'h01, 8'h00, 1'b0);
      beat(3'd4, 2'd2, 8'h01, 8'h00, 1'b0);
      pulse_reset();
      idle_cycle();
      chk("rstpkt_no_output", 32'(out_valid), 32'd0);
      beat(3'd0, 2'd2, 8'h5A, 8'h00, 1'b1);
      chk("rstpkt_valid", 32'(out_valid), 32'd1);
      chk("rstpkt_y",     32'(out_y),     32'h5A);
      chk("rstpkt_beats", 32'(out_beats), 32'd1);
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
